// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller (32 x 256-bit lines).
// Define DCACHE_STATS_EN to add the hit_count_o / miss_count_o statistics ports.
module dcache_ctrl #(
   parameter int LINE_NUM = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  p1_addr_i,
   input  logic [31:0]  p1_data_i,
   input  logic         p1_MemRead_i,
   input  logic         p1_MemWrite_i,
   output logic [31:0]  p1_data_o,
   output logic         p1_stall_o,
`ifdef DCACHE_STATS_EN
   output logic [31:0]  hit_count_o,
   output logic [31:0]  miss_count_o,
`endif
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
);

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_e;

   state_e state_q, state_d;

   logic [LINE_NUM-1:0] valid_q, valid_d;
   logic [LINE_NUM-1:0] dirty_q, dirty_d;
   logic [21:0]         tag_q  [LINE_NUM];
   logic [255:0]        data_q [LINE_NUM];

   logic [21:0]  req_tag;
   logic [4:0]   idx;
   logic [2:0]   word;
   logic         req;
   logic         tag_match;
   logic         hit;
   logic         load_hit;
   logic         store_hit;
   logic [21:0]  cur_tag;
   logic [255:0] cur_line;

   logic         line_we;
   logic [255:0] line_d;
   logic         tag_we;
   logic [21:0]  tag_d;

   logic         unused_addr_bits;

   assign req_tag          = p1_addr_i[31:10];
   assign idx              = p1_addr_i[9:5];
   assign word             = p1_addr_i[4:2];
   assign unused_addr_bits = ^p1_addr_i[1:0];

   assign req      = p1_MemRead_i | p1_MemWrite_i;
   assign cur_tag  = tag_q[idx];
   assign cur_line = data_q[idx];

   // A lookup only counts as a hit in IDLE; during a fill the held request stays stalled
   // until the controller has walked back to IDLE.
   assign tag_match = valid_q[idx] && (cur_tag == req_tag);
   assign hit       = req && tag_match && (state_q == IDLE);
   assign store_hit = hit && p1_MemWrite_i;
   assign load_hit  = hit && p1_MemRead_i && !p1_MemWrite_i;

   assign p1_stall_o = req && !hit;
   assign p1_data_o  = load_hit ? cur_line[{word, 5'b0} +: 32] : 32'd0;

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      line_we      = 1'b0;
      line_d       = cur_line;
      tag_we       = 1'b0;
      tag_d        = cur_tag;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'd0;
      mem_data_o   = 256'd0;

      unique case (state_q)
         IDLE: begin
            if (store_hit) begin
               line_we                   = 1'b1;
               line_d[{word, 5'b0} +: 32] = p1_data_i;
               dirty_d[idx]              = 1'b1;
            end else if (req && !tag_match) begin
               state_d = MISS;
            end
         end
         MISS: begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : READMISS;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {cur_tag, idx, 5'b0};
            mem_data_o   = cur_line;
            if (mem_ack_i) begin
               state_d = READMISS;
            end
         end
         READMISS: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {req_tag, idx, 5'b0};
            if (mem_ack_i) begin
               line_we      = 1'b1;
               line_d       = mem_data_i;
               tag_we       = 1'b1;
               tag_d        = req_tag;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = READMISSOK;
            end
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data arrays are never cleared; a write coinciding with reset is dropped.
   always_ff @(posedge clk_i) begin
      if (line_we && !rst_i) begin
         data_q[idx] <= line_d;
      end
      if (tag_we && !rst_i) begin
         tag_q[idx] <= tag_d;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        fill_done_q, fill_done_d;

   // The IDLE hit that immediately follows a fill is the completion of an already-counted miss.
   always_comb begin
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      fill_done_d = (state_q == READMISSOK);
      if (hit && !fill_done_q) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && req && !tag_match) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_q   <= 32'd0;
         miss_cnt_q  <= 32'd0;
         fill_done_q <= 1'b0;
      end else begin
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         fill_done_q <= fill_done_d;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif

endmodule
